// File: rtl/usb_tx_data_buffer.sv
// TX byte FIFO between the AHB-Lite store path and usb_tx; show-ahead head byte,
// 1/2/4-byte little-endian stores, single-byte pops, sticky overflow/underflow flags.
module usb_tx_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        store_en,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  input  logic        Get_TX_Packet_Data,
  output logic [7:0]  TX_Packet_Data,
  output logic [6:0]  Buffer_Occupancy,
  output logic        buffer_full,
  output logic        overflow_err,
  output logic        underflow_err
);

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [6:0]        r_occ;
  logic              r_ovf;
  logic              r_unf;

  logic [2:0]        w_n;
  logic [6:0]        w_free;
  logic              w_store_acc;
  logic              w_store_rej;
  logic              w_pop_ok;
  logic              w_pop_bad;
  logic [6:0]        w_occ_next;
  logic [3:0]        w_lane_we;
  logic [ADDR_W-1:0] w_lane_addr [4];
  logic [7:0]        w_lane_data [4];

  // store_size 3 maps to zero bytes so it can never be accepted
  always_comb begin
    w_n = 3'd0;
    case (store_size)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      2'd2:    w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  // acceptance uses start-of-cycle occupancy; a same-cycle pop is not credited
  assign w_free      = DEPTH_C - r_occ;
  assign w_store_acc = store_en && (w_n != 3'd0) && ({4'd0, w_n} <= w_free);
  assign w_store_rej = store_en && !w_store_acc;
  assign w_pop_ok    = Get_TX_Packet_Data && (r_occ != 7'd0);
  assign w_pop_bad   = Get_TX_Packet_Data && (r_occ == 7'd0);
  assign w_occ_next  = r_occ + (w_store_acc ? {4'd0, w_n} : 7'd0)
                             - (w_pop_ok ? 7'd1 : 7'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi]   = w_store_acc && (w_n > 3'(gi));
      assign w_lane_addr[gi] = r_wr_ptr + ADDR_W'(gi);
      assign w_lane_data[gi] = store_data[8*gi +: 8];
    end
  endgenerate

  // storage is not reset; clear only drops pointers so contents survive
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_we[i]) begin
          r_mem[w_lane_addr[i]] <= w_lane_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= 7'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_store_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(w_n);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_occ <= w_occ_next;
      if (w_store_rej) begin
        r_ovf <= 1'b1;
      end
      if (w_pop_bad) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign TX_Packet_Data   = (r_occ != 7'd0) ? r_mem[r_rd_ptr] : 8'h00;
  assign Buffer_Occupancy = r_occ;
  assign buffer_full      = (r_occ == DEPTH_C);
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule
